// File: rtl/instruction_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath: instruction/target
// inputs plus PC, register-file, ALU and data-memory controls.
interface instruction_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] target_data;
    logic             ir_en;
    logic             pc_add;
    logic             pc_branch;
    logic             pc_jump;
    logic [3:0]       flag_op;
    logic [WIDTH-1:0] immediate;
    logic [3:0]       rf_src;
    logic [3:0]       rf_dst;
    logic             rf_we;
    logic             link_we;
    logic [3:0]       alu_op;
    logic             alu_imm_sel;
    logic             flag_we;
    logic             mem_we;
    logic             mem_rd;
    logic             illegal;

    modport master (
        input  instr, target_data,
        output ir_en, pc_add, pc_branch, pc_jump, flag_op, immediate, rf_src, rf_dst,
               rf_we, link_we, alu_op, alu_imm_sel, flag_we, mem_we, mem_rd, illegal
    );

    modport slave (
        output instr, target_data,
        input  ir_en, pc_add, pc_branch, pc_jump, flag_op, immediate, rf_src, rf_dst,
               rf_we, link_we, alu_op, alu_imm_sel, flag_we, mem_we, mem_rd, illegal
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC(/MEM_WAIT/WB) control FSM for the 16-bit core.
// Define ILLEGAL_TRAP_EN to trap illegal encodings into HALT instead of running them as NOPs.
module instruction_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DISP_W = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    instruction_sequencer_if.master         bus
);
    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM_WAIT = 3'd3,
        WB       = 3'd4,
        HALT     = 3'd5
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] ir;
    logic [3:0]       op;
    logic [3:0]       ext;

    function automatic logic [WIDTH-1:0] sext(input logic [DISP_W-1:0] v);
        return {{(WIDTH-DISP_W){v[DISP_W-1]}}, v};
    endfunction

    assign op  = ir[15:12];
    assign ext = ir[7:4];

    // State and instruction register; stall freezes both, reset wins over stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            ir    <= {WIDTH{1'b0}};
        end else if (!stall) begin
            state <= nextState;
            if (state == DECODE) begin
                ir <= bus.instr;
            end else begin
                ir <= ir;
            end
        end else begin
            state <= state;
            ir    <= ir;
        end
    end

    // Next-state and decoded control outputs; reset and stall mask every output.
    always_comb begin
        nextState       = state;
        bus.ir_en       = 1'b0;
        bus.pc_add      = 1'b0;
        bus.pc_branch   = 1'b0;
        bus.pc_jump     = 1'b0;
        bus.flag_op     = 4'b0000;
        bus.immediate   = {WIDTH{1'b0}};
        bus.rf_src      = 4'b0000;
        bus.rf_dst      = 4'b0000;
        bus.rf_we       = 1'b0;
        bus.link_we     = 1'b0;
        bus.alu_op      = 4'b0000;
        bus.alu_imm_sel = 1'b0;
        bus.flag_we     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.illegal     = 1'b0;
        if (!reset) begin
            nextState = FETCH;
        end else if (stall) begin
            nextState = state;
        end else begin
            case (state)
                FETCH: begin
                    nextState = DECODE;
                end
                DECODE: begin
                    bus.ir_en = 1'b1;
                    nextState = EXEC;
                end
                EXEC: begin
                    nextState  = FETCH;
                    bus.rf_src = ir[3:0];
                    bus.rf_dst = ir[11:8];
                    case (op)
                        4'b0000: begin
                            bus.alu_op  = ext;
                            bus.rf_we   = (ext != 4'b1011);
                            bus.flag_we = 1'b1;
                            bus.pc_add  = 1'b1;
                        end
                        4'b1100: begin
                            bus.pc_branch = 1'b1;
                            bus.flag_op   = ir[11:8];
                            bus.immediate = sext(ir[DISP_W-1:0]);
                        end
                        4'b0100: begin
                            case (ext)
                                4'b1100: begin
                                    bus.pc_jump   = 1'b1;
                                    bus.flag_op   = ir[11:8];
                                    bus.immediate = bus.target_data;
                                end
                                4'b1000: begin
                                    bus.pc_jump   = 1'b1;
                                    bus.flag_op   = 4'b1111;
                                    bus.link_we   = 1'b1;
                                    bus.immediate = bus.target_data;
                                end
                                4'b0000: begin
                                    bus.mem_rd = 1'b1;
                                    nextState  = MEM_WAIT;
                                end
                                4'b0100: begin
                                    bus.mem_we = 1'b1;
                                    bus.pc_add = 1'b1;
                                end
                                default: begin
                                    bus.rf_src = 4'b0000;
                                    bus.rf_dst = 4'b0000;
`ifdef ILLEGAL_TRAP_EN
                                    bus.illegal = 1'b1;
                                    nextState   = HALT;
`else
                                    bus.pc_add  = 1'b1;
`endif
                                end
                            endcase
                        end
                        default: begin
                            bus.alu_op      = op;
                            bus.alu_imm_sel = 1'b1;
                            bus.immediate   = sext(ir[DISP_W-1:0]);
                            bus.rf_we       = (op != 4'b1011);
                            bus.flag_we     = 1'b1;
                            bus.pc_add      = 1'b1;
                        end
                    endcase
                end
                MEM_WAIT: begin
                    nextState = WB;
                end
                WB: begin
                    bus.rf_src = ir[3:0];
                    bus.rf_dst = ir[11:8];
                    bus.rf_we  = 1'b1;
                    bus.pc_add = 1'b1;
                    nextState  = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                HALT: begin
                    bus.illegal = 1'b1;
                    nextState   = HALT;
                end
`endif
                default: begin
                    nextState = FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed, table-driven bench for instruction_sequencer plus hand-written stall/reset/LOAD
// sequences and a per-cycle PC-strobe exclusivity monitor.
module tb_instruction_sequencer;
    typedef struct packed {
        logic        ir_en;
        logic        pc_add;
        logic        pc_branch;
        logic        pc_jump;
        logic [3:0]  flag_op;
        logic [15:0] immediate;
        logic [3:0]  rf_src;
        logic [3:0]  rf_dst;
        logic        rf_we;
        logic        link_we;
        logic [3:0]  alu_op;
        logic        alu_imm_sel;
        logic        flag_we;
        logic        mem_we;
        logic        mem_rd;
        logic        illegal;
    } outs_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] td;
        outs_t       exp;
        string       name;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  stall = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    strobes = 0;
    outs_t got;
    outs_t zero;
    outs_t decodeExp;
    vec_t  v[10];

    instruction_sequencer_if #(.WIDTH(16)) bus ();

    instruction_sequencer #(.WIDTH(16), .DISP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign got = {bus.ir_en, bus.pc_add, bus.pc_branch, bus.pc_jump, bus.flag_op, bus.immediate,
                  bus.rf_src, bus.rf_dst, bus.rf_we, bus.link_we, bus.alu_op, bus.alu_imm_sel,
                  bus.flag_we, bus.mem_we, bus.mem_rd, bus.illegal};

    // PC strobes must be one-hot-or-idle every cycle; also tallies strobes for per-instruction counts.
    always @(negedge clk) begin
        checks++;
        if ($countones({bus.pc_add, bus.pc_branch, bus.pc_jump}) > 1 ||
            $isunknown({bus.pc_add, bus.pc_branch, bus.pc_jump})) begin
            errors++;
            $display("FAIL pc_strobe_exclusive: got add=%b branch=%b jump=%b, want at most one",
                     bus.pc_add, bus.pc_branch, bus.pc_jump);
        end
        strobes += int'(bus.pc_add) + int'(bus.pc_branch) + int'(bus.pc_jump);
    end

    function automatic outs_t mk(logic pa, logic pb, logic pj, logic [3:0] fop, logic [15:0] imm,
                                 logic [3:0] src, logic [3:0] dst, logic we, logic lk,
                                 logic [3:0] alu, logic isel, logic fwe, logic mwe, logic mrd);
        outs_t o;
        o = '0;
        o.pc_add = pa; o.pc_branch = pb; o.pc_jump = pj; o.flag_op = fop; o.immediate = imm;
        o.rf_src = src; o.rf_dst = dst; o.rf_we = we; o.link_we = lk; o.alu_op = alu;
        o.alu_imm_sel = isel; o.flag_we = fwe; o.mem_we = mwe; o.mem_rd = mrd;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input outs_t exp);
        #1;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chkCount(input string name, input int actual, input int want);
        checks++;
        if (actual != want) begin
            errors++;
            $display("FAIL %s: got %0d strobes expected %0d", name, actual, want);
        end
    endtask

    initial begin
        int s0;
        outs_t e;
        zero      = '0;
        decodeExp = '0;
        decodeExp.ir_en = 1'b1;

        v[0] = '{16'h0152, 16'h0000, mk(1'b1,1'b0,1'b0,4'h0,16'h0000,4'h2,4'h1,1'b1,1'b0,4'h5,1'b0,1'b1,1'b0,1'b0), "add_r1_r2"};
        v[1] = '{16'hC0FD, 16'h0000, mk(1'b0,1'b1,1'b0,4'h0,16'hFFFD,4'hD,4'h0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0), "beq_m3"};
        v[2] = '{16'h4E83, 16'h0000, mk(1'b0,1'b0,1'b1,4'hF,16'h0000,4'h3,4'hE,1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,1'b0), "jal_r14_r3"};
        v[3] = '{16'h4EC5, 16'h0123, mk(1'b0,1'b0,1'b1,4'hE,16'h0123,4'h5,4'hE,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0), "jcond_uc_r5"};
        v[4] = '{16'h4347, 16'h0000, mk(1'b1,1'b0,1'b0,4'h0,16'h0000,4'h7,4'h3,1'b0,1'b0,4'h0,1'b0,1'b0,1'b1,1'b0), "stor_r3_r7"};
        v[5] = '{16'h5285, 16'h0000, mk(1'b1,1'b0,1'b0,4'h0,16'hFF85,4'h5,4'h2,1'b1,1'b0,4'h5,1'b1,1'b1,1'b0,1'b0), "itype_neg_imm"};
        v[6] = '{16'h627F, 16'h0000, mk(1'b1,1'b0,1'b0,4'h0,16'h007F,4'hF,4'h2,1'b1,1'b0,4'h6,1'b1,1'b1,1'b0,1'b0), "itype_max_pos"};
        v[7] = '{16'h03B4, 16'h0000, mk(1'b1,1'b0,1'b0,4'h0,16'h0000,4'h4,4'h3,1'b0,1'b0,4'hB,1'b0,1'b1,1'b0,1'b0), "cmp_rtype"};
        v[8] = '{16'hB1FF, 16'h0000, mk(1'b1,1'b0,1'b0,4'h0,16'hFFFF,4'hF,4'h1,1'b0,1'b0,4'hB,1'b1,1'b1,1'b0,1'b0), "cmpi_itype"};
        v[9] = '{16'hC17F, 16'h0000, mk(1'b0,1'b1,1'b0,4'h1,16'h007F,4'hF,4'h1,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0), "bne_p127"};

        bus.instr = 16'h0152;
        bus.target_data = 16'h0000;
        chk("reset_t0", zero);
        tick(); chk("reset_c1", zero);
        tick(); chk("reset_c2", zero);
        reset = 1'b1;

        // release cycle is FETCH, DECODE follows, EXEC on the third cycle
        for (int i = 0; i < 10; i++) begin
            bus.instr = v[i].instr;
            bus.target_data = v[i].td;
            s0 = strobes;
            chk({v[i].name, "_fetch"}, zero);
            tick(); chk({v[i].name, "_decode"}, decodeExp);
            tick(); chk({v[i].name, "_exec"}, v[i].exp);
            tick();
            chkCount({v[i].name, "_strobes"}, strobes - s0, 1);
        end

        // stall held in EXEC: outputs masked, strobe issued once after release
        bus.instr = 16'h0152;
        s0 = strobes;
        tick(); tick();
        stall = 1'b1;
        chk("exec_stall_0", zero);
        tick(); chk("exec_stall_1", zero);
        tick(); chk("exec_stall_2", zero);
        stall = 1'b0;
        chk("exec_resume", v[0].exp);
        tick(); chk("exec_after_fetch", zero);
        chkCount("exec_stall_strobes", strobes - s0, 1);

        // LOAD with a three-cycle stall in MEM_WAIT
        bus.instr = 16'h4207;
        s0 = strobes;
        tick(); chk("load_decode", decodeExp);
        tick(); chk("load_exec", mk(1'b0,1'b0,1'b0,4'h0,16'h0000,4'h7,4'h2,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b1));
        tick();
        stall = 1'b1;
        chk("load_mw_stall_0", zero);
        tick(); chk("load_mw_stall_1", zero);
        tick(); chk("load_mw_stall_2", zero);
        stall = 1'b0;
        chk("load_mem_wait", zero);
        tick(); chk("load_wb", mk(1'b1,1'b0,1'b0,4'h0,16'h0000,4'h7,4'h2,1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0));
        tick(); chk("load_next_fetch", zero);
        chkCount("load_strobes", strobes - s0, 1);

        // reset asserted in EXEC aborts the instruction with no strobe
        bus.instr = 16'h0152;
        tick(); tick();
        reset = 1'b0;
        s0 = strobes;
        chk("abort_exec_masked", zero);
        tick(); chk("abort_fetch", zero);
        chkCount("abort_strobes", strobes - s0, 0);
        reset = 1'b1;
        tick(); chk("abort_redecode", decodeExp);
        tick(); chk("abort_reexec", v[0].exp);
        tick();

        // illegal 0100 extension
        bus.instr = 16'h4010;
        s0 = strobes;
        tick(); chk("illegal_decode", decodeExp);
        tick();
`ifdef ILLEGAL_TRAP_EN
        e = '0;
        e.illegal = 1'b1;
        chk("illegal_trap_exec", e);
        tick(); chk("illegal_halt_0", e);
        tick(); chk("illegal_halt_1", e);
        stall = 1'b1;
        chk("illegal_halt_stall", zero);
        stall = 1'b0;
        tick();
        chkCount("illegal_trap_strobes", strobes - s0, 0);
`else
        e = mk(1'b1,1'b0,1'b0,4'h0,16'h0000,4'h0,4'h0,1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0);
        chk("illegal_nop_exec", e);
        tick(); chk("illegal_nop_fetch", zero);
        chkCount("illegal_nop_strobes", strobes - s0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
